// File: rtl/lv_pwm_code_pkg.sv
// Package for the multi-channel LV-side PWM code decoder.
// Holds the per-channel FSM state type and the helper that derives the
// burst-code width from the largest legal edge count.
package lv_pwm_code_pkg;

  // Per-channel burst FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_OVF   = 2'd2
  } ch_state_e;

  // Default for the largest legal edge count per burst
  localparam int DEF_MAX_EDGE = 7;

  // Width needed to hold an edge count 0..max_edge
  function automatic int code_w_f(input int max_edge);
    return $clog2(max_edge + 1);
  endfunction

endpackage

// File: rtl/gnrl_sync.sv
// Generic multi-bit two-flop synchroniser.
// Ports:
//   clk    - destination clock
//   rst_n  - asynchronous active-low reset, flops load RST_VAL
//   d      - asynchronous input bits
//   q      - synchronised output (two clk stages of latency)
module gnrl_sync #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage1_q, stage1_d;
  logic [W-1:0] stage2_q, stage2_d;

  always_comb begin
    stage1_d = d;
    stage2_d = stage1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1_q <= RST_VAL;
      stage2_q <= RST_VAL;
    end else begin
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
    end
  end

  assign q = stage2_q;

endmodule

// File: rtl/lv_pwm_code_ch.sv
// One decoder channel: synchroniser, glitch filter, gap counter, burst FSM
// and registered code / interrupt outputs.
// Ports:
//   i_clk, i_rst_n - clock and asynchronous active-low reset
//   i_pwm_n        - raw asynchronous PWM/INTB line, idle high
//   i_ch_en        - channel decode enable (synchronous)
//   o_intb_n       - decoded interrupt level, active low
//   o_code_vld     - one-cycle pulse, o_code carries a new burst code
//   o_code         - last emitted burst code (edge count)
//   o_ovf_err      - one-cycle pulse, burst had more than MAX_EDGE edges
module lv_pwm_code_ch
  import lv_pwm_code_pkg::*;
#(
  parameter int FLT_CYC  = 4,
  parameter int GAP_CYC  = 9,
  parameter int MAX_EDGE = DEF_MAX_EDGE,
  parameter int SET_CODE = 1,
  parameter int CLR_CODE = 3
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_pwm_n,
  input  logic                            i_ch_en,
  output logic                            o_intb_n,
  output logic                            o_code_vld,
  output logic [code_w_f(MAX_EDGE)-1:0]   o_code,
  output logic                            o_ovf_err
);

  localparam int CODE_W = code_w_f(MAX_EDGE);
  localparam int STAB_W = $clog2(FLT_CYC + 1);
  localparam int GAP_W  = $clog2(GAP_CYC + 1);

  logic              sync_n;
  logic              flt_q, flt_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic              edge_q, edge_d;
  logic              edge_v;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              gap_end;
  ch_state_e         state_q, state_d;
  logic [CODE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              code_vld_q, code_vld_d;
  logic              ovf_err_q, ovf_err_d;
  logic              intb_q, intb_d;

  gnrl_sync #(.W(1), .RST_VAL(1'b1)) u_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (i_pwm_n),
    .q     (sync_n)
  );

  // Glitch filter. The line is one bit, so a synced value that changes while
  // differing from the filtered level can only be returning to it; both reset
  // cases collapse to "synced equals filtered". The filter runs regardless of
  // enable so that re-enabling never sees a stale level.
  always_comb begin
    stab_cnt_d = '0;
    flt_d      = flt_q;
    edge_d     = 1'b0;
    if (sync_n != flt_q) begin
      if (stab_cnt_q == STAB_W'(FLT_CYC - 1)) begin
        flt_d  = sync_n;
        edge_d = 1'b1;
      end else begin
        stab_cnt_d = stab_cnt_q + STAB_W'(1);
      end
    end
  end

  assign edge_v = edge_q & i_ch_en;

  // Gap counter: cleared by an edge, otherwise counts up and saturates
  always_comb begin
    gap_d = gap_q;
    if (!i_ch_en || edge_v) begin
      gap_d = '0;
    end else if (gap_q != GAP_W'(GAP_CYC)) begin
      gap_d = gap_q + GAP_W'(1);
    end
  end

  // An edge in the expiry cycle keeps the burst alive
  assign gap_end = i_ch_en & ~edge_v & (gap_q == GAP_W'(GAP_CYC - 1));

  // Filter, gap and edge-pulse registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      flt_q      <= 1'b1;
      stab_cnt_q <= '0;
      edge_q     <= 1'b0;
      gap_q      <= '0;
    end else begin
      flt_q      <= flt_d;
      stab_cnt_q <= stab_cnt_d;
      edge_q     <= edge_d;
      gap_q      <= gap_d;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (!i_ch_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (edge_v) state_d = ST_BURST;
        ST_BURST: begin
          if (edge_v && (edge_cnt_q == CODE_W'(MAX_EDGE))) state_d = ST_OVF;
          else if (gap_end)                                state_d = ST_IDLE;
        end
        ST_OVF:   if (gap_end) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: edge count and the registered code / level / error pulses
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    code_d     = code_q;
    code_vld_d = 1'b0;
    ovf_err_d  = 1'b0;
    intb_d     = intb_q;
    if (!i_ch_en) begin
      edge_cnt_d = '0;
      intb_d     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (edge_v) edge_cnt_d = CODE_W'(1);
        ST_BURST: begin
          if (edge_v) begin
            if (edge_cnt_q != CODE_W'(MAX_EDGE)) edge_cnt_d = edge_cnt_q + CODE_W'(1);
          end else if (gap_end) begin
            code_vld_d = 1'b1;
            code_d     = edge_cnt_q;
            edge_cnt_d = '0;
            if (edge_cnt_q == CODE_W'(SET_CODE))      intb_d = 1'b0;
            else if (edge_cnt_q == CODE_W'(CLR_CODE)) intb_d = 1'b1;
          end
        end
        ST_OVF: begin
          if (gap_end) begin
            ovf_err_d  = 1'b1;
            edge_cnt_d = '0;
          end
        end
        default: edge_cnt_d = '0;
      endcase
    end
  end

  // Burst bookkeeping and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      edge_cnt_q <= '0;
      code_q     <= '0;
      code_vld_q <= 1'b0;
      ovf_err_q  <= 1'b0;
      intb_q     <= 1'b1;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      code_q     <= code_d;
      code_vld_q <= code_vld_d;
      ovf_err_q  <= ovf_err_d;
      intb_q     <= intb_d;
    end
  end

  assign o_intb_n   = intb_q;
  assign o_code_vld = code_vld_q;
  assign o_code     = code_q;
  assign o_ovf_err  = ovf_err_q;

endmodule

// File: rtl/lv_pwm_code_decode.sv
// Multi-channel LV-side PWM burst-code decoder.
// Replicates one decoder channel per HV PWM/INTB line and merges the
// per-channel interrupt levels.
// Ports:
//   i_clk, i_rst_n - clock and asynchronous active-low reset
//   i_pwm_n        - raw HV PWM/INTB lines, idle high
//   i_ch_en        - per-channel decode enable
//   o_pwm_gwave    - combinational pass-through of i_pwm_n
//   o_intb_n       - per-channel interrupt level, active low
//   o_intb_all_n   - low when any channel interrupt is asserted
//   o_code_vld     - per-channel code-valid pulse
//   o_code         - per-channel burst code, channel k at [k*CODE_W +: CODE_W]
//   o_ovf_err      - per-channel overflow pulse
module lv_pwm_code_decode
  import lv_pwm_code_pkg::*;
#(
  parameter int CH_NUM   = 2,
  parameter int FLT_CYC  = 4,
  parameter int GAP_CYC  = 9,
  parameter int MAX_EDGE = DEF_MAX_EDGE,
  parameter int SET_CODE = 1,
  parameter int CLR_CODE = 3
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic [CH_NUM-1:0]                      i_pwm_n,
  input  logic [CH_NUM-1:0]                      i_ch_en,
  output logic [CH_NUM-1:0]                      o_pwm_gwave,
  output logic [CH_NUM-1:0]                      o_intb_n,
  output logic                                   o_intb_all_n,
  output logic [CH_NUM-1:0]                      o_code_vld,
  output logic [CH_NUM*code_w_f(MAX_EDGE)-1:0]   o_code,
  output logic [CH_NUM-1:0]                      o_ovf_err
);

  localparam int CODE_W = code_w_f(MAX_EDGE);

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    lv_pwm_code_ch #(
      .FLT_CYC  (FLT_CYC),
      .GAP_CYC  (GAP_CYC),
      .MAX_EDGE (MAX_EDGE),
      .SET_CODE (SET_CODE),
      .CLR_CODE (CLR_CODE)
    ) u_ch (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_pwm_n    (i_pwm_n[k]),
      .i_ch_en    (i_ch_en[k]),
      .o_intb_n   (o_intb_n[k]),
      .o_code_vld (o_code_vld[k]),
      .o_code     (o_code[k*CODE_W +: CODE_W]),
      .o_ovf_err  (o_ovf_err[k])
    );
  end

  assign o_pwm_gwave  = i_pwm_n;
  assign o_intb_all_n = &o_intb_n;

endmodule

// File: tb/tb_lv_pwm_code_decode.sv
// Directed self-checking bench for lv_pwm_code_decode with default
// parameters (2 channels, filter 4, gap 9, max 7 edges, set 1, clear 3).
// Inputs are driven 1 time unit after a rising edge; an input change shows
// up as a filtered edge 6 cycles later and a code 10 cycles after the last
// edge, i.e. 16 cycles after the last input change.
module tb_lv_pwm_code_decode;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] pwm_n = 2'b11;
  logic [1:0] ch_en = 2'b11;

  logic [1:0] o_pwm_gwave;
  logic [1:0] o_intb_n;
  logic       o_intb_all_n;
  logic [1:0] o_code_vld;
  logic [5:0] o_code;
  logic [1:0] o_ovf_err;

  int total  = 0;
  int passed = 0;
  logic [1:0] seen_vld = 2'b00;
  logic [1:0] seen_err = 2'b00;

  lv_pwm_code_decode dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_pwm_n      (pwm_n),
    .i_ch_en      (ch_en),
    .o_pwm_gwave  (o_pwm_gwave),
    .o_intb_n     (o_intb_n),
    .o_intb_all_n (o_intb_all_n),
    .o_code_vld   (o_code_vld),
    .o_code       (o_code),
    .o_ovf_err    (o_ovf_err)
  );

  always #5 clk = ~clk;

  // Advance n cycles, sampling 1 unit after each rising edge and
  // accumulating any pulse seen on the vld / err outputs
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      seen_vld = seen_vld | o_code_vld;
      seen_err = seen_err | o_ovf_err;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pwm_n = 2'b11; ch_en = 2'b11;
    run_cycles(3);
    total++; if (o_intb_n !== 2'b11) $display("[TB] FAIL rst_intb: got %b expected %b", o_intb_n, 2'b11); else passed++;
    total++; if (o_intb_all_n !== 1'b1) $display("[TB] FAIL rst_intb_all: got %b expected 1", o_intb_all_n); else passed++;
    total++; if (o_code_vld !== 2'b00) $display("[TB] FAIL rst_vld: got %b expected 00", o_code_vld); else passed++;
    total++; if (o_ovf_err !== 2'b00) $display("[TB] FAIL rst_err: got %b expected 00", o_ovf_err); else passed++;
    total++; if (o_code !== 6'd0) $display("[TB] FAIL rst_code: got %h expected 0", o_code); else passed++;
    pwm_n = 2'b01;
    #1;
    total++; if (o_pwm_gwave !== 2'b01) $display("[TB] FAIL gwave: got %b expected 01", o_pwm_gwave); else passed++;
    pwm_n = 2'b11;
    run_cycles(1);
    rst_n = 1'b1;
    run_cycles(12);
  endtask

  task automatic test_two_edges();
    seen_vld = 2'b00;
    pwm_n[0] = 1'b0;
    run_cycles(6);
    pwm_n[0] = 1'b1;
    run_cycles(15);
    total++; if (seen_vld !== 2'b00) $display("[TB] FAIL t1_early_vld: got %b expected 00", seen_vld); else passed++;
    run_cycles(1);
    total++; if (o_code_vld !== 2'b01) $display("[TB] FAIL t1_vld: got %b expected 01", o_code_vld); else passed++;
    total++; if (o_code[2:0] !== 3'd2) $display("[TB] FAIL t1_code: got %0d expected 2", o_code[2:0]); else passed++;
    total++; if (o_intb_n !== 2'b11) $display("[TB] FAIL t1_intb: got %b expected 11", o_intb_n); else passed++;
    run_cycles(1);
    total++; if (o_code_vld !== 2'b00) $display("[TB] FAIL t1_vld_pulse: got %b expected 00", o_code_vld); else passed++;
    total++; if (o_code[2:0] !== 3'd2) $display("[TB] FAIL t1_code_hold: got %0d expected 2", o_code[2:0]); else passed++;
    run_cycles(4);
  endtask

  task automatic test_set_clear();
    seen_vld = 2'b00;
    pwm_n[0] = 1'b0;
    run_cycles(15);
    total++; if (seen_vld !== 2'b00) $display("[TB] FAIL t2_set_early: got %b expected 00", seen_vld); else passed++;
    run_cycles(1);
    total++; if (o_code_vld !== 2'b01) $display("[TB] FAIL t2_set_vld: got %b expected 01", o_code_vld); else passed++;
    total++; if (o_code[2:0] !== 3'd1) $display("[TB] FAIL t2_set_code: got %0d expected 1", o_code[2:0]); else passed++;
    total++; if (o_intb_n !== 2'b10) $display("[TB] FAIL t2_set_intb: got %b expected 10", o_intb_n); else passed++;
    total++; if (o_intb_all_n !== 1'b0) $display("[TB] FAIL t2_set_all: got %b expected 0", o_intb_all_n); else passed++;
    run_cycles(2);
    seen_vld = 2'b00;
    pwm_n[0] = 1'b1;
    run_cycles(6);
    pwm_n[0] = 1'b0;
    run_cycles(6);
    pwm_n[0] = 1'b1;
    run_cycles(15);
    total++; if (seen_vld !== 2'b00) $display("[TB] FAIL t2_clr_early: got %b expected 00", seen_vld); else passed++;
    run_cycles(1);
    total++; if (o_code_vld !== 2'b01) $display("[TB] FAIL t2_clr_vld: got %b expected 01", o_code_vld); else passed++;
    total++; if (o_code[2:0] !== 3'd3) $display("[TB] FAIL t2_clr_code: got %0d expected 3", o_code[2:0]); else passed++;
    total++; if (o_intb_n !== 2'b11) $display("[TB] FAIL t2_clr_intb: got %b expected 11", o_intb_n); else passed++;
    total++; if (o_intb_all_n !== 1'b1) $display("[TB] FAIL t2_clr_all: got %b expected 1", o_intb_all_n); else passed++;
    run_cycles(4);
  endtask

  task automatic test_glitch();
    seen_vld = 2'b00; seen_err = 2'b00;
    pwm_n[1] = 1'b0;
    run_cycles(2);
    pwm_n[1] = 1'b1;
    run_cycles(10);
    pwm_n[1] = 1'b0;
    run_cycles(3);
    pwm_n[1] = 1'b1;
    run_cycles(30);
    total++; if (seen_vld !== 2'b00) $display("[TB] FAIL t3_vld: got %b expected 00", seen_vld); else passed++;
    total++; if (seen_err !== 2'b00) $display("[TB] FAIL t3_err: got %b expected 00", seen_err); else passed++;
    total++; if (o_code[5:3] !== 3'd0) $display("[TB] FAIL t3_code1: got %0d expected 0", o_code[5:3]); else passed++;
    total++; if (o_intb_n !== 2'b11) $display("[TB] FAIL t3_intb: got %b expected 11", o_intb_n); else passed++;
  endtask

  task automatic test_overflow();
    seen_vld = 2'b00; seen_err = 2'b00;
    for (int i = 0; i < 8; i++) begin
      pwm_n[0] = ~pwm_n[0];
      if (i < 7) run_cycles(6);
    end
    run_cycles(15);
    total++; if (seen_err !== 2'b00) $display("[TB] FAIL t4_early_err: got %b expected 00", seen_err); else passed++;
    run_cycles(1);
    total++; if (o_ovf_err !== 2'b01) $display("[TB] FAIL t4_err: got %b expected 01", o_ovf_err); else passed++;
    run_cycles(1);
    total++; if (o_ovf_err !== 2'b00) $display("[TB] FAIL t4_err_pulse: got %b expected 00", o_ovf_err); else passed++;
    total++; if (seen_vld !== 2'b00) $display("[TB] FAIL t4_no_vld: got %b expected 00", seen_vld); else passed++;
    total++; if (o_code[2:0] !== 3'd3) $display("[TB] FAIL t4_code_hold: got %0d expected 3", o_code[2:0]); else passed++;
    run_cycles(12);
  endtask

  task automatic test_gap_edge_and_channels();
    // ch1 single edge sets its interrupt
    pwm_n[1] = 1'b0;
    run_cycles(16);
    total++; if (o_code_vld !== 2'b10) $display("[TB] FAIL t5_ch1_set_vld: got %b expected 10", o_code_vld); else passed++;
    total++; if (o_code[5:3] !== 3'd1) $display("[TB] FAIL t5_ch1_set_code: got %0d expected 1", o_code[5:3]); else passed++;
    total++; if (o_intb_n !== 2'b01) $display("[TB] FAIL t5_ch1_set_intb: got %b expected 01", o_intb_n); else passed++;
    run_cycles(12);
    // ch0 single edge (set); ch1 three edges spaced exactly at gap expiry
    seen_vld = 2'b00;
    pwm_n = 2'b10;
    run_cycles(9);
    pwm_n[1] = 1'b0;
    run_cycles(7);
    total++; if (o_code_vld !== 2'b01) $display("[TB] FAIL t5_ch0_vld: got %b expected 01", o_code_vld); else passed++;
    total++; if (o_code[2:0] !== 3'd1) $display("[TB] FAIL t5_ch0_code: got %0d expected 1", o_code[2:0]); else passed++;
    total++; if (o_intb_n !== 2'b00) $display("[TB] FAIL t5_both_low: got %b expected 00", o_intb_n); else passed++;
    run_cycles(2);
    pwm_n[1] = 1'b1;
    run_cycles(15);
    total++; if (seen_vld[1] !== 1'b0) $display("[TB] FAIL t5_ch1_early: got %b expected 0", seen_vld[1]); else passed++;
    run_cycles(1);
    total++; if (o_code_vld !== 2'b10) $display("[TB] FAIL t5_ch1_vld: got %b expected 10", o_code_vld); else passed++;
    total++; if (o_code !== {3'd3, 3'd1}) $display("[TB] FAIL t5_codes: got %h expected %h", o_code, {3'd3, 3'd1}); else passed++;
    total++; if (o_intb_n !== 2'b10) $display("[TB] FAIL t5_intb: got %b expected 10", o_intb_n); else passed++;
    total++; if (o_intb_all_n !== 1'b0) $display("[TB] FAIL t5_all: got %b expected 0", o_intb_all_n); else passed++;
    run_cycles(12);
  endtask

  task automatic test_enable();
    seen_vld = 2'b00; seen_err = 2'b00;
    pwm_n[0] = 1'b1;
    run_cycles(8);
    pwm_n[0] = 1'b0;
    run_cycles(2);
    ch_en[0] = 1'b0;
    run_cycles(2);
    total++; if (o_intb_n[0] !== 1'b1) $display("[TB] FAIL t6_dis_intb: got %b expected 1", o_intb_n[0]); else passed++;
    run_cycles(18);
    total++; if (seen_vld !== 2'b00) $display("[TB] FAIL t6_dis_vld: got %b expected 00", seen_vld); else passed++;
    total++; if (seen_err !== 2'b00) $display("[TB] FAIL t6_dis_err: got %b expected 00", seen_err); else passed++;
    ch_en[0] = 1'b1;
    run_cycles(25);
    total++; if (seen_vld[0] !== 1'b0) $display("[TB] FAIL t6_reen_vld: got %b expected 0", seen_vld[0]); else passed++;
    total++; if (o_intb_n !== 2'b11) $display("[TB] FAIL t6_reen_intb: got %b expected 11", o_intb_n); else passed++;
    total++; if (o_code[2:0] !== 3'd1) $display("[TB] FAIL t6_reen_code: got %0d expected 1", o_code[2:0]); else passed++;
  endtask

  task automatic test_reset_mid_burst();
    pwm_n[1] = 1'b0;
    run_cycles(8);
    rst_n = 1'b0;
    #2;
    total++; if (o_intb_n !== 2'b11) $display("[TB] FAIL t7_intb: got %b expected 11", o_intb_n); else passed++;
    total++; if (o_intb_all_n !== 1'b1) $display("[TB] FAIL t7_all: got %b expected 1", o_intb_all_n); else passed++;
    total++; if (o_code !== 6'd0) $display("[TB] FAIL t7_code: got %h expected 0", o_code); else passed++;
    total++; if ({o_code_vld, o_ovf_err} !== 4'b0000) $display("[TB] FAIL t7_pulses: got %b expected 0000", {o_code_vld, o_ovf_err}); else passed++;
    pwm_n = 2'b11;
    run_cycles(3);
    rst_n = 1'b1;
    seen_vld = 2'b00; seen_err = 2'b00;
    run_cycles(30);
    total++; if ({seen_vld, seen_err} !== 4'b0000) $display("[TB] FAIL t7_quiet: got %b expected 0000", {seen_vld, seen_err}); else passed++;
  endtask

  initial begin
    test_reset();
    test_two_edges();
    test_set_clear();
    test_glitch();
    test_overflow();
    test_gap_edge_and_channels();
    test_enable();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
